// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for ram_stream_reader: address-width helper and FSM state encoding.
package ram_stream_reader_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/ram_stream_reader_stream_buf2.sv
// Two-entry valid/ready FIFO with registered outputs; head entry drives the stream directly.
module ram_stream_reader_stream_buf2 #(
   parameter int WIDTH = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count
);

   logic             r_head_valid;
   logic             r_tail_valid;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic             w_pop;

   assign w_pop = r_head_valid & i_ready;

   // NOTE: data registers are reset as well, because the stream data output must read 0 in reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_head_valid <= 1'b0;
         r_tail_valid <= 1'b0;
         r_head       <= '0;
         r_tail       <= '0;
      end else if (w_pop || !r_head_valid) begin
         // Head slot is free next cycle: refill from tail first, then from the incoming word.
         if (r_tail_valid) begin
            r_head       <= r_tail;
            r_head_valid <= 1'b1;
            r_tail_valid <= i_push;
            if (i_push) r_tail <= i_data;
         end else begin
            r_head_valid <= i_push;
            if (i_push) r_head <= i_data;
         end
      end else if (i_push) begin
         r_tail_valid <= 1'b1;
         r_tail       <= i_data;
      end
   end

   assign o_valid = r_head_valid;
   assign o_data  = r_head;
   assign o_count = {r_head_valid & r_tail_valid, r_head_valid ^ r_tail_valid};

   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(i_push && r_tail_valid && !w_pop));

endmodule

// File: rtl/ram_stream_reader.sv
// RAM read-side stream master: reads `length` words from `start_addr` into a valid/ready stream.
// Define RAM_STREAM_READER_WRAP_EN for circular addressing; otherwise transfers stop at the last RAM word.
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int RAM_SIZE  = 640,
   parameter int LEN_BITW  = 16,
   parameter int ADDR_BITW = clog2(RAM_SIZE)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_BITW-1:0] start_addr,
   input  logic [LEN_BITW-1:0]  length,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITW-1:0] rd_addr,
   input  logic [WORD_SIZE-1:0] rd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_data,
   output logic                 out_last
);

   localparam logic [ADDR_BITW-1:0] LAST_ADDR = ADDR_BITW'(RAM_SIZE - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [LEN_BITW-1:0]  r_remaining;
   logic [ADDR_BITW-1:0] r_rd_addr;
   logic                 r_inflight;
   logic                 r_inflight_last;
   logic                 r_done;
   logic                 w_done_nxt;
   logic                 w_issue;
   logic                 w_issue_last;
   logic                 w_at_end;
   logic                 w_pop;
   logic [1:0]           w_count;
   logic [2:0]           w_occ;
   logic                 w_buf_valid;
   logic                 w_buf_last;
   logic [WORD_SIZE-1:0] w_buf_data;

   assign w_pop    = w_buf_valid & out_ready;
   // Occupancy after this cycle's pop; a new read may only be issued if it still fits.
   assign w_occ    = {2'b00, r_inflight} + {1'b0, w_count} - {2'b00, w_pop};
   assign w_issue  = (r_state == ST_READ) && (r_remaining != '0) && (w_occ < 3'd2);
   assign w_at_end = (r_rd_addr == LAST_ADDR);

`ifdef RAM_STREAM_READER_WRAP_EN
   assign w_issue_last = (r_remaining == LEN_BITW'(1));
`else
   assign w_issue_last = (r_remaining == LEN_BITW'(1)) || w_at_end;
`endif

   // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) w_state_nxt = ST_READ;
               else              w_done_nxt  = 1'b1;
            end
         end
         ST_READ: begin
            if (w_issue && w_issue_last) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_pop && w_buf_last) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_remaining     <= '0;
         r_rd_addr       <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_done          <= w_done_nxt;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue & w_issue_last;
         if (r_state == ST_IDLE && start) begin
            r_rd_addr   <= start_addr;
            r_remaining <= length;
         end else if (w_issue) begin
            r_remaining <= w_issue_last ? '0 : r_remaining - LEN_BITW'(1);
            if (!w_at_end) begin
               r_rd_addr <= r_rd_addr + ADDR_BITW'(1);
            end
`ifdef RAM_STREAM_READER_WRAP_EN
            else begin
               r_rd_addr <= '0;
            end
`endif
         end
      end
   end

   ram_stream_reader_stream_buf2 #(
      .WIDTH(WORD_SIZE + 1)
   ) u_buf (
      .clock  (clock),
      .reset  (reset),
      .i_push (r_inflight),
      .i_data ({r_inflight_last, rd_data}),
      .i_ready(out_ready),
      .o_valid(w_buf_valid),
      .o_data ({w_buf_last, w_buf_data}),
      .o_count(w_count)
   );

   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign rd_addr   = r_rd_addr;
   assign out_valid = w_buf_valid;
   assign out_data  = w_buf_data;
   assign out_last  = w_buf_last;

endmodule
